// File: rtl/rgb_pkg.sv
// Shared types and constants for the RGB sequencer: FSM states, widths and the AUTO colour table.
package rgb_pkg;

  typedef enum logic [1:0] {
    StManual,
    StAuto,
    StPause
  } state_e;

  localparam int unsigned RGB_W  = 3;
  localparam int unsigned STEP_W = 3;
  localparam int unsigned PWM_W  = 4;

  // {R,G,B} per AUTO step, index 0 first
  localparam logic [RGB_W-1:0] COLOR_TABLE [8] = '{
    3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101, 3'b111, 3'b000
  };

endpackage

// File: rtl/btn_debounce.sv
// Push-button debouncer: DEB_LEN-sample shift register, hysteretic level, one-cycle press pulse.
module btn_debounce #(
  parameter int unsigned DEB_LEN = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic btn,
  output logic level,
  output logic press
);

  logic [DEB_LEN-1:0] sh_q;
  logic               level_q;
  logic               level_prev_q;

  always_ff @(posedge clk) begin
    if (!clr) begin
      sh_q         <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
    end else begin
      sh_q <= {sh_q[DEB_LEN-2:0], btn};
      // Level only moves on a unanimous history; mixed samples hold it
      if (&sh_q) begin
        level_q <= 1'b1;
      end else if (~|sh_q) begin
        level_q <= 1'b0;
      end
      level_prev_q <= level_q;
    end
  end

  assign level = level_q;
  assign press = level_q & ~level_prev_q;

endmodule

// File: rtl/rgb_seq_ctrl.sv
// RGB LED sequencer: MANUAL/AUTO/PAUSE FSM driven by debounced load and mode buttons.
// Optional PWM dimming of the LED drive is enabled by defining RGB_PWM_EN.
module rgb_seq_ctrl
  import rgb_pkg::*;
#(
  parameter int unsigned DEB_LEN  = 4,
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              btn_load,
  input  logic              btn_mode,
  input  logic [RGB_W-1:0]  sw,
`ifdef RGB_PWM_EN
  input  logic [PWM_W-1:0]  duty,
`endif
  output logic [RGB_W-1:0]  rgb_out,
  output logic              load_stb,
  output logic              mode_auto,
  output logic [STEP_W-1:0] step_idx
);

  localparam int unsigned           TICK_W    = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic load_lvl, load_p;
  logic mode_lvl, mode_p;

  btn_debounce #(.DEB_LEN(DEB_LEN)) u_deb_load (
    .clk   (clk),
    .clr   (clr),
    .btn   (btn_load),
    .level (load_lvl),
    .press (load_p)
  );

  btn_debounce #(.DEB_LEN(DEB_LEN)) u_deb_mode (
    .clk   (clk),
    .clr   (clr),
    .btn   (btn_mode),
    .level (mode_lvl),
    .press (mode_p)
  );

  state_e              state_q;
  logic [RGB_W-1:0]    rgb_q;
  logic                stb_q;
  logic                mode_auto_q;
  logic [STEP_W-1:0]   step_q;
  logic [STEP_W-1:0]   step_nxt;
  logic [TICK_W-1:0]   tick_q;

  assign step_nxt = step_q + STEP_W'(1);

  // mode_p is tested first everywhere so it wins over load_p and over a terminal tick
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q     <= StManual;
      rgb_q       <= '0;
      stb_q       <= 1'b0;
      mode_auto_q <= 1'b0;
      step_q      <= '0;
      tick_q      <= '0;
    end else begin
      stb_q <= 1'b0;
      case (state_q)
        StManual: begin
          if (mode_p) begin
            state_q     <= StAuto;
            mode_auto_q <= 1'b1;
            step_q      <= '0;
            tick_q      <= '0;
            rgb_q       <= COLOR_TABLE[0];
            stb_q       <= 1'b1;
          end else if (load_p) begin
            rgb_q <= sw;
            stb_q <= 1'b1;
          end
        end
        StAuto: begin
          if (mode_p) begin
            state_q     <= StManual;
            mode_auto_q <= 1'b0;
          end else if (load_p) begin
            state_q <= StPause;
          end else if (tick_q == TICK_LAST) begin
            tick_q <= '0;
            step_q <= step_nxt;
            rgb_q  <= COLOR_TABLE[step_nxt];
            stb_q  <= 1'b1;
          end else begin
            tick_q <= tick_q + TICK_W'(1);
          end
        end
        StPause: begin
          if (mode_p) begin
            state_q     <= StManual;
            mode_auto_q <= 1'b0;
          end else if (load_p) begin
            state_q <= StAuto;
          end
        end
        default: begin
          state_q     <= StManual;
          mode_auto_q <= 1'b0;
        end
      endcase
    end
  end

  assign load_stb  = stb_q;
  assign mode_auto = mode_auto_q;
  assign step_idx  = step_q;

`ifdef RGB_PWM_EN
  logic [PWM_W-1:0] pwm_cnt_q;
  logic [RGB_W-1:0] led_q;

  always_ff @(posedge clk) begin
    if (!clr) begin
      pwm_cnt_q <= '0;
      led_q     <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
      led_q     <= rgb_q & {RGB_W{pwm_cnt_q < duty}};
    end
  end

  assign rgb_out = led_q;
`else
  assign rgb_out = rgb_q;
`endif

endmodule

// File: tb/tb_rgb_seq_ctrl.sv
// Scoreboard bench for rgb_seq_ctrl (DEB_LEN=4, TICK_DIV=4): directed button/switch sequences.
module tb_rgb_seq_ctrl;

  localparam int unsigned DEB  = 4;
  localparam int unsigned TDIV = 4;

  localparam logic [2:0] COLOR [8] = '{
    3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101, 3'b111, 3'b000
  };

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       btn_load = 1'b0;
  logic       btn_mode = 1'b0;
  logic [2:0] sw = 3'b000;
  logic [2:0] rgb_out;
  logic       load_stb;
  logic       mode_auto;
  logic [2:0] step_idx;
`ifdef RGB_PWM_EN
  logic [3:0] duty = 4'd15;
`endif

  rgb_seq_ctrl #(.DEB_LEN(DEB), .TICK_DIV(TDIV)) dut (
    .clk       (clk),
    .clr       (clr),
    .btn_load  (btn_load),
    .btn_mode  (btn_mode),
    .sw        (sw),
`ifdef RGB_PWM_EN
    .duty      (duty),
`endif
    .rgb_out   (rgb_out),
    .load_stb  (load_stb),
    .mode_auto (mode_auto),
    .step_idx  (step_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] rgb;
    logic [2:0] step;
    logic       mode;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   stb_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_upd(input logic [2:0] r, input logic [2:0] s, input logic m);
    sb.push_back(exp_t'{rgb: r, step: s, mode: m});
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold long enough for exactly one debounced press; action lands on the last held edge
  task automatic press(input logic l, input logic m);
    btn_load = l;
    btn_mode = m;
    wait_edges(DEB + 2);
    btn_load = 1'b0;
    btn_mode = 1'b0;
  endtask

  // Monitor: every load_stb must match the next queued update
  always @(negedge clk) begin : monitor
    exp_t e;
    if (load_stb === 1'b1) begin
      stb_seen++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_stb: got rgb %b step %0d, expected no update", rgb_out,
                 step_idx);
      end else begin
        e = sb.pop_front();
        check("sb_rgb", 32'(rgb_out), 32'(e.rgb));
        check("sb_step", 32'(step_idx), 32'(e.step));
        check("sb_mode", 32'(mode_auto), 32'(e.mode));
      end
    end
  end

  initial begin
    logic [5:0] pat;

    // Reset state
    wait_edges(3);
    check("rst_rgb", 32'(rgb_out), 0);
    check("rst_stb", 32'(load_stb), 0);
    check("rst_mode", 32'(mode_auto), 0);
    check("rst_step", 32'(step_idx), 0);
    clr = 1'b1;
    wait_edges(2);

    // Manual load, long hold: single update 5 edges after first sample
    sw = 3'b101;
    expect_upd(3'b101, 3'd0, 1'b0);
    btn_load = 1'b1;
    wait_edges(5);
    check("load_not_early", 32'(rgb_out), 0);
    wait_edges(1);
    check("load_rgb", 32'(rgb_out), 32'(3'b101));
    check("load_stb_hi", 32'(load_stb), 1);
    wait_edges(1);
    check("load_stb_one_cycle", 32'(load_stb), 0);
    wait_edges(1);
    btn_load = 1'b0;
    wait_edges(8);
    check("load_held_rgb", 32'(rgb_out), 32'(3'b101));
    check("load_single_stb", 32'(stb_seen), 1);

    // Bounce reject
    sw  = 3'b011;
    pat = 6'b101101;
    for (int i = 5; i >= 0; i--) begin
      btn_load = pat[i];
      wait_edges(1);
    end
    btn_load = 1'b0;
    wait_edges(10);
    check("bounce_rgb", 32'(rgb_out), 32'(3'b101));
    check("bounce_no_stb", 32'(stb_seen), 1);

    // AUTO entry and a full table lap
    expect_upd(COLOR[0], 3'd0, 1'b1);
    press(1'b0, 1'b1);
    check("auto_entry_rgb", 32'(rgb_out), 32'(3'b100));
    check("auto_entry_mode", 32'(mode_auto), 1);
    check("auto_entry_stb", 32'(load_stb), 1);
    for (int s = 1; s <= 8; s++) begin
      expect_upd(COLOR[s % 8], 3'(s % 8), 1'b1);
      wait_edges(3);
      check("auto_hold_between", 32'(load_stb), 0);
      wait_edges(1);
      check("auto_step_rgb", 32'(rgb_out), 32'(COLOR[s % 8]));
      check("auto_step_idx", 32'(step_idx), 32'(s % 8));
      check("auto_step_stb", 32'(load_stb), 1);
    end

    // Pause at step 3 with tick frozen at 2
    expect_upd(3'b110, 3'd1, 1'b1);
    expect_upd(3'b010, 3'd2, 1'b1);
    expect_upd(3'b011, 3'd3, 1'b1);
    wait_edges(9);
    press(1'b1, 1'b0);
    check("pause_rgb", 32'(rgb_out), 32'(3'b011));
    check("pause_step", 32'(step_idx), 3);
    check("pause_mode", 32'(mode_auto), 1);
    wait_edges(20);
    check("pause_frozen_rgb", 32'(rgb_out), 32'(3'b011));
    check("pause_no_stb", 32'(stb_seen), 13);

    // Resume: next step exactly 2 cycles after the resume edge
    expect_upd(3'b001, 3'd4, 1'b1);
    press(1'b1, 1'b0);
    check("resume_edge_rgb", 32'(rgb_out), 32'(3'b011));
    wait_edges(1);
    check("resume_plus1_rgb", 32'(rgb_out), 32'(3'b011));
    wait_edges(1);
    check("resume_step_rgb", 32'(rgb_out), 32'(3'b001));
    check("resume_step_idx", 32'(step_idx), 4);

    // Two more steps, then pause again (tick=1 at step 6)
    expect_upd(3'b101, 3'd5, 1'b1);
    expect_upd(3'b111, 3'd6, 1'b1);
    wait_edges(4);
    press(1'b1, 1'b0);
    check("pause2_rgb", 32'(rgb_out), 32'(3'b111));
    check("pause2_step", 32'(step_idx), 6);

    // Simultaneous presses in PAUSE: mode wins
    wait_edges(6);
    press(1'b1, 1'b1);
    check("simul_mode", 32'(mode_auto), 0);
    check("simul_rgb", 32'(rgb_out), 32'(3'b111));
    check("simul_stb", 32'(load_stb), 0);
    wait_edges(10);
    check("simul_held_rgb", 32'(rgb_out), 32'(3'b111));
    check("simul_stb_count", 32'(stb_seen), 16);

    // Manual load of an unchanged value still strobes; then a new value
    sw = 3'b111;
    expect_upd(3'b111, 3'd6, 1'b0);
    press(1'b1, 1'b0);
    check("same_val_stb", 32'(load_stb), 1);
    wait_edges(6);
    sw = 3'b010;
    expect_upd(3'b010, 3'd6, 1'b0);
    press(1'b1, 1'b0);
    check("manual2_rgb", 32'(rgb_out), 32'(3'b010));
    wait_edges(6);

    // Reset mid-AUTO
    expect_upd(3'b100, 3'd0, 1'b1);
    expect_upd(3'b110, 3'd1, 1'b1);
    press(1'b0, 1'b1);
    wait_edges(5);
    clr = 1'b0;
    wait_edges(1);
    check("midrst_rgb", 32'(rgb_out), 0);
    check("midrst_mode", 32'(mode_auto), 0);
    check("midrst_step", 32'(step_idx), 0);
    check("midrst_stb", 32'(load_stb), 0);
    wait_edges(2);
    clr = 1'b1;
    wait_edges(10);
    check("post_rst_manual_rgb", 32'(rgb_out), 0);
    check("post_rst_manual_mode", 32'(mode_auto), 0);

    check("sb_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
